// File: rtl/usb3_tx_scramble_skp.sv
// usb3_tx_scramble_skp
//
// USB 3.0 TX scrambler with SKP ordered-set insertion. It sits between the
// link-layer TX mux and the PIPE TX interface and has one register stage.
//
// Every consumed input word advances a symbol counter. Each SKP_INTERVAL
// symbols earn one SKP credit, and credits wait in a small saturating queue.
// When insertion is allowed, the input word is stalled for one cycle and a
// word of SKP symbols (BYTES/2 ordered sets) goes out in its place.
//
// Data symbols are scrambled by the x^16+x^5+x^4+x^3+1 LFSR. The lanes are
// handled in time order (lane 0 first), and a COM on any lane reseeds the
// LFSR for the lanes after it.
//
// Ports:
//   local_clk         clock
//   reset_n           synchronous, active-low reset
//   scram_en          1 = scramble D symbols; 0 = pass through, LFSR held at seed
//   skp_en            1 = symbol counter and SKP insertion active
//   skp_inhibit       block insertion; credits keep accumulating
//   skp_defer         postpone insertion this cycle
//   raw_datak/raw_data  input word (K flags / symbols, lane 0 in bits [7:0])
//   raw_active        packet in flight; no insertion while 1
//   raw_stall         combinational; 1 = input word not consumed this cycle
//   proc_datak/proc_data  registered output word
//   skp_queued        pending SKP ordered-set count
//   err_skp_overflow  sticky; a credit was dropped because the queue was full
module usb3_tx_scramble_skp #(
    parameter int          BYTES        = 4,
    parameter int          SKP_INTERVAL = 354,
    parameter int          MAX_QUEUED   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hFFFF
) (
    input  logic                 local_clk,
    input  logic                 reset_n,
    input  logic                 scram_en,
    input  logic                 skp_en,
    input  logic                 skp_inhibit,
    input  logic                 skp_defer,
    input  logic [BYTES-1:0]     raw_datak,
    input  logic [8*BYTES-1:0]   raw_data,
    input  logic                 raw_active,
    output logic                 raw_stall,
    output logic [BYTES-1:0]     proc_datak,
    output logic [8*BYTES-1:0]   proc_data,
    output logic [2:0]           skp_queued,
    output logic                 err_skp_overflow
);

    localparam int CW = $clog2(SKP_INTERVAL + BYTES);
    localparam logic [CW-1:0] BYTES_C    = CW'(BYTES);
    localparam logic [CW-1:0] INTERVAL_C = CW'(SKP_INTERVAL);
    localparam logic [2:0]    HALF_C     = 3'(BYTES / 2);
    localparam logic [2:0]    MAX_C      = 3'(MAX_QUEUED);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h3C;

    // Galois form of the scrambler. Each output bit is the LFSR MSB, taken
    // before the shift. Byte bit 0 is used first.
    function automatic logic [7:0] lfsr_key(input logic [15:0] s);
        logic [15:0] st;
        logic [7:0]  key;
        st  = s;
        key = 8'h00;
        for (int i = 0; i < 8; i++) begin
            key[i] = st[15];
            st     = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
        end
        return key;
    endfunction

    function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
        logic [15:0] st;
        st = s;
        for (int i = 0; i < 8; i++) begin
            st = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
        end
        return st;
    endfunction

    logic [15:0]        lfsr_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2:0]         queue_reg;
    logic               err_reg;
    logic [8*BYTES-1:0] proc_data_reg;
    logic [BYTES-1:0]   proc_datak_reg;

    logic               ins;
    logic [8*BYTES-1:0] scram_data;
    logic [15:0]        lfsr_chain_out;

    assign ins = skp_en & (queue_reg != 3'd0) & ~raw_active & ~skp_defer & ~skp_inhibit;
    assign raw_stall = ins;

    // Per-lane scrambler stage. Each lane takes the LFSR state left by the
    // previous lane, so the whole word is processed in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [15:0] lfsr_in;
            logic [15:0] lfsr_out;
            logic [7:0]  sym_in;
            logic [7:0]  sym_out;
            logic        is_k;
            logic        is_com;
            logic        is_skp;

            if (gi == 0) begin : g_first
                assign lfsr_in = lfsr_reg;
            end else begin : g_rest
                assign lfsr_in = g_lane[gi-1].lfsr_out;
            end

            assign sym_in = raw_data[8*gi +: 8];
            assign is_k   = raw_datak[gi];
            assign is_com = is_k && (sym_in == SYM_COM);
            assign is_skp = is_k && (sym_in == SYM_SKP);

            always_comb begin
                lfsr_out = lfsr_in;
                sym_out  = sym_in;
                if (!scram_en || is_com) begin
                    lfsr_out = LFSR_SEED;
                end else if (!is_skp) begin
                    // K symbols other than SKP still step the LFSR.
                    lfsr_out = lfsr_adv8(lfsr_in);
                    if (!is_k) begin
                        sym_out = sym_in ^ lfsr_key(lfsr_in);
                    end
                end
            end

            assign scram_data[8*gi +: 8] = sym_out;
        end
    endgenerate

    assign lfsr_chain_out = g_lane[BYTES-1].lfsr_out;

    // Symbol counter and credit generation. The remainder carries over when
    // the interval is crossed, so credits do not drift when BYTES does not
    // divide SKP_INTERVAL.
    logic [CW-1:0] cnt_sum;
    logic          credit;

    assign cnt_sum = cnt_reg + BYTES_C;
    assign credit  = skp_en & ~ins & (cnt_sum >= INTERVAL_C);

    // One SKP word carries BYTES/2 ordered sets. A single pending set is
    // still sent as a whole word.
    logic [2:0] dec;
    logic [2:0] queue_next;
    logic       overflow;

    always_comb begin
        dec        = 3'd0;
        queue_next = queue_reg;
        overflow   = 1'b0;
        if (ins) begin
            dec = (queue_reg < HALF_C) ? queue_reg : HALF_C;
        end
        if (credit) begin
            if (queue_reg == MAX_C && dec == 3'd0) begin
                overflow = 1'b1;
            end else begin
                queue_next = queue_reg + 3'd1 - dec;
            end
        end else begin
            queue_next = queue_reg - dec;
        end
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            lfsr_reg       <= LFSR_SEED;
            cnt_reg        <= '0;
            queue_reg      <= 3'd0;
            err_reg        <= 1'b0;
            proc_data_reg  <= '0;
            proc_datak_reg <= '0;
        end else begin
            if (ins) begin
                proc_data_reg  <= {BYTES{SYM_SKP}};
                proc_datak_reg <= {BYTES{1'b1}};
            end else begin
                proc_data_reg  <= scram_data;
                proc_datak_reg <= raw_datak;
            end

            // The held word is scrambled later, so the LFSR must not move
            // during an inserted SKP word.
            if (!scram_en) begin
                lfsr_reg <= LFSR_SEED;
            end else if (!ins) begin
                lfsr_reg <= lfsr_chain_out;
            end

            if (!skp_en) begin
                cnt_reg <= '0;
            end else if (!ins) begin
                cnt_reg <= (cnt_sum >= INTERVAL_C) ? (cnt_sum - INTERVAL_C) : cnt_sum;
            end

            queue_reg <= queue_next;
            if (overflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign proc_data        = proc_data_reg;
    assign proc_datak       = proc_datak_reg;
    assign skp_queued       = queue_reg;
    assign err_skp_overflow = err_reg;

endmodule

// File: tb/tb_usb3_tx_scramble_skp.sv
// Testbench for usb3_tx_scramble_skp (BYTES=4, SKP_INTERVAL=16, MAX_QUEUED=4).
// It drives a linear sequence of directed steps. Expected output words go
// into a scoreboard queue when a word is driven and are popped when the
// registered output appears. Scrambler expectations are taken from a
// keystream table built bit-serially from the seed and indexed by the
// number of bytes since the last reseed.
module tb_usb3_tx_scramble_skp;

    localparam int BYTES = 4;
    localparam int INTERVAL = 16;
    localparam int MAXQ = 4;
    localparam int KS_LEN = 4096;

    logic        local_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scram_en = 1'b1;
    logic        skp_en = 1'b0;
    logic        skp_inhibit = 1'b0;
    logic        skp_defer = 1'b0;
    logic [3:0]  raw_datak = 4'h0;
    logic [31:0] raw_data = 32'h0;
    logic        raw_active = 1'b0;
    logic        raw_stall;
    logic [3:0]  proc_datak;
    logic [31:0] proc_data;
    logic [2:0]  skp_queued;
    logic        err_skp_overflow;

    usb3_tx_scramble_skp #(
        .BYTES(BYTES), .SKP_INTERVAL(INTERVAL), .MAX_QUEUED(MAXQ), .LFSR_SEED(16'hFFFF)
    ) dut (
        .local_clk(local_clk), .reset_n(reset_n), .scram_en(scram_en), .skp_en(skp_en),
        .skp_inhibit(skp_inhibit), .skp_defer(skp_defer), .raw_datak(raw_datak),
        .raw_data(raw_data), .raw_active(raw_active), .raw_stall(raw_stall),
        .proc_datak(proc_datak), .proc_data(proc_data), .skp_queued(skp_queued),
        .err_skp_overflow(err_skp_overflow)
    );

    always #5 local_clk = ~local_clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ks[KS_LEN];
    int         errors = 0;
    int         checks = 0;

    // Reference model state.
    int m_q = 0;
    int m_cnt = 0;
    int m_err = 0;
    int ks_pos = 0;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q = 0;
        m_cnt = 0;
        m_err = 0;
        ks_pos = 0;
        sb.delete();
    endfunction

    function automatic logic [7:0] ks_at(int p);
        if (p < KS_LEN) return ks[p];
        return 8'h00;
    endfunction

    // Drive one word until the DUT consumes it. Every cycle, compare the
    // stall, the output word and the queue/error state. Report the number
    // of stall cycles.
    task automatic step(input logic [31:0] d, input logic [3:0] k, input logic act,
                        input logic dfr, input logic inh, output int stalls);
        bit   done;
        bit   m_ins;
        exp_t e;
        exp_t got;
        done = 0;
        stalls = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            raw_data = d; raw_datak = k; raw_active = act; skp_defer = dfr; skp_inhibit = inh;
            #1;
            m_ins = skp_en && (m_q != 0) && !act && !dfr && !inh;
            chk("raw_stall", {31'd0, raw_stall}, {31'd0, m_ins});
            if (m_ins) begin
                e.d = 32'h3C3C3C3C;
                e.k = 4'hF;
                m_q = m_q - ((m_q < BYTES / 2) ? m_q : BYTES / 2);
                stalls++;
                if (!scram_en) ks_pos = 0;
            end else begin
                for (int l = 0; l < BYTES; l++) begin
                    logic [7:0] b;
                    b = d[8*l +: 8];
                    e.d[8*l +: 8] = b;
                    if (!scram_en) ks_pos = 0;
                    else if (k[l] && b == 8'hBC) ks_pos = 0;
                    else if (k[l] && b == 8'h3C) ks_pos = ks_pos;
                    else if (k[l]) ks_pos++;
                    else begin
                        e.d[8*l +: 8] = b ^ ks_at(ks_pos);
                        ks_pos++;
                    end
                end
                e.k = k;
                if (!skp_en) m_cnt = 0;
                else begin
                    m_cnt += BYTES;
                    if (m_cnt >= INTERVAL) begin
                        m_cnt -= INTERVAL;
                        if (m_q == MAXQ) m_err = 1;
                        else m_q++;
                    end
                end
                done = 1;
            end
            sb.push_back(e);
            @(posedge local_clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                chk("proc_data", proc_data, got.d);
                chk("proc_datak", {28'd0, proc_datak}, {28'd0, got.k});
            end
            chk("skp_queued", {29'd0, skp_queued}, 32'(m_q));
            chk("err_skp_overflow", {31'd0, err_skp_overflow}, 32'(m_err));
            @(negedge local_clk);
        end
        if (!done) chk("consume_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int st;
        int total;
        logic [15:0] s;

        // Keystream: byte n is what scrambles the n-th data byte after a seed load.
        s = 16'hFFFF;
        for (int n = 0; n < KS_LEN; n++) begin
            for (int i = 0; i < 8; i++) begin
                ks[n][i] = s[15];
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
            end
        end

        // Reset state.
        repeat (2) @(posedge local_clk);
        #1;
        chk("reset_proc_data", proc_data, 32'h0);
        chk("reset_proc_datak", {28'd0, proc_datak}, 32'h0);
        chk("reset_skp_queued", {29'd0, skp_queued}, 32'h0);
        chk("reset_err", {31'd0, err_skp_overflow}, 32'h0);
        chk("reset_stall", {31'd0, raw_stall}, 32'h0);
        @(negedge local_clk);
        reset_n = 1'b1;
        model_reset();

        // COM in lane 0, then zeros: check against the fixed spec sequence.
        step(32'h000000BC, 4'b0001, 1'b0, 1'b0, 1'b0, st);
        chk("com_lane0_word", proc_data, 32'hC017FFBC);
        step(32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("seq_continue", proc_data & 32'h00FFFFFF, 32'h00E7B214);

        // COM in lane 2: lane 3 uses the reseeded LFSR.
        step(32'h00BC0000, 4'b0100, 1'b0, 1'b0, 1'b0, st);
        chk("com_lane2_l3", {24'd0, proc_data[31:24]}, 32'h000000FF);

        // Random mixed words, including SKP and other K symbols.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rd;
            logic [3:0]  rk;
            rd = $urandom;
            rk = 4'($urandom_range(0, 15)) & 4'b0101;
            if (i == 2) begin rd[15:8] = 8'h3C; rk[1] = 1'b1; end
            step(rd, rk, 1'b0, 1'b0, 1'b0, st);
        end

        // Pass-through with scrambling off.
        scram_en = 1'b0;
        step(32'hA5C3BC00, 4'b0010, 1'b0, 1'b0, 1'b0, st);
        chk("passthrough", proc_data, 32'hA5C3BC00);
        scram_en = 1'b1;
        step(32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("reseed_after_off", proc_data, 32'h14C017FF);

        // Continuous input with SKP enabled: one credit per 4 words.
        skp_en = 1'b1;
        total = 0;
        for (int i = 0; i < 12; i++) begin
            step(32'h11223344 + i, 4'b0000, 1'b0, 1'b0, 1'b0, st);
            total += st;
        end
        chk("skp_stalls_12w", 32'(total), 32'd2);
        step(32'h55667788, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("skp_stall_last", 32'(st), 32'd1);
        chk("queue_drained", {29'd0, skp_queued}, 32'd0);

        // Zero the counter, then saturate the queue during a long packet.
        skp_en = 1'b0;
        step(32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        skp_en = 1'b1;
        for (int i = 0; i < 40; i++) step(32'hC0DE0000 + i, 4'b0000, 1'b1, 1'b0, 1'b0, st);
        chk("sat_queue", {29'd0, skp_queued}, 32'd4);
        chk("sat_err", {31'd0, err_skp_overflow}, 32'd1);
        step(32'hBEEF0001, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("sat_drain_stalls", 32'(st), 32'd2);

        // Build a credit, then test inhibit and defer.
        for (int i = 0; i < 8 && m_q == 0; i++) step(32'h0F0F0000 + i, 4'b0000, 1'b1, 1'b0, 1'b0, st);
        step(32'h12340001, 4'b0000, 1'b0, 1'b0, 1'b1, st);
        chk("inhibit_no_stall", 32'(st), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(32'h56780000 + i, 4'b0000, 1'b0, 1'b1, 1'b0, st);
            chk("defer_no_stall", 32'(st), 32'd0);
        end
        step(32'h9ABC0000, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("defer_single_skp", 32'(st), 32'd1);

        // Reset in the middle of an insertion with three sets pending.
        for (int i = 0; i < 40 && m_q != 3; i++) step(32'h77770000 + i, 4'b0000, 1'b1, 1'b0, 1'b0, st);
        chk("pre_reset_queue", {29'd0, skp_queued}, 32'd3);
        raw_active = 1'b0; raw_data = 32'h0; raw_datak = 4'h0;
        #1;
        chk("pre_reset_stall", {31'd0, raw_stall}, 32'd1);
        reset_n = 1'b0;
        @(posedge local_clk);
        #1;
        chk("midins_proc_data", proc_data, 32'h0);
        chk("midins_proc_datak", {28'd0, proc_datak}, 32'h0);
        chk("midins_queue", {29'd0, skp_queued}, 32'h0);
        chk("midins_stall", {31'd0, raw_stall}, 32'h0);
        @(negedge local_clk);
        reset_n = 1'b1;
        model_reset();
        step(32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("post_reset_seed", proc_data, 32'h14C017FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb3_tx_scramble_skp.md
Name: usb3_tx_scramble_skp

Overview:
- Parametrised USB 3.0 TX scrambler with SKP ordered-set insertion.
- Sits between the link-layer TX mux and the PIPE TX interface.
- Generalises the fixed 32-bit scrambler:
  - configurable lane count
  - configurable SKP interval and queue depth
  - independent scramble and SKP enables
  - honoured skp_inhibit and skp_defer
  - per-symbol spec-exact LFSR with COM reset at any lane
  - queue-overflow reporting

Parameters:
- BYTES, 4, symbols per word; legal values 2 or 4; lane 0 is first in time.
- SKP_INTERVAL, 354, data symbols between SKP ordered-set credits.
- MAX_QUEUED, 4, saturation limit of pending SKP sets (1..7).
- LFSR_SEED, 16'hFFFF, scrambler value loaded at reset and after every COM.

Ports:
- local_clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- scram_en  in  1  1 = scramble D symbols; 0 = pass through, LFSR held at LFSR_SEED
- skp_en  in  1  1 = SKP counter and insertion active
- skp_inhibit  in  1  block insertion; counter and queue keep accumulating
- skp_defer  in  1  postpone insertion this cycle (e.g. mid-header)
- raw_datak  in  BYTES  K flags
- raw_data  in  8*BYTES  symbols
- raw_active  in  1  packet in flight; no insertion while 1
- raw_stall  out  1  combinational; 1 = input word not consumed this cycle
- proc_datak  out  BYTES  registered K flags
- proc_data  out  8*BYTES  registered symbols
- skp_queued  out  3  current pending SKP set count
- err_skp_overflow  out  1  sticky; a credit was dropped at saturation

Behaviour:
- Reset (reset_n=0 at a clock edge) sets:
  - proc_data = 0 and proc_datak = 0
  - symbol counter, queue and err_skp_overflow = 0
  - LFSR = LFSR_SEED
  - raw_stall = 0 on the following cycle
- Reset mid-insertion aborts the insertion; the queue is lost.
- Insertion decision:
  - ins = skp_en & (queue != 0) & ~raw_active & ~skp_defer & ~skp_inhibit
  - raw_stall = ins
  - Upstream must hold raw_* stable while raw_stall = 1.
- Latency: one register stage.
  - ins = 0: the input word appears on proc_* at the next edge (after scrambling).
  - ins = 1: proc_* carries a SKP word at the next edge; the held input word follows later.
- SKP word content:
  - All lanes 8'h3C, all K.
  - Represents BYTES/2 ordered sets.
  - Queue decrements by min(queue, BYTES/2), so over-insertion by one set is permitted.
- Scrambling:
  - Polynomial x^16+x^5+x^4+x^3+1; output byte per USB 3.0 §6.4.1 / Appendix B.
  - Lanes are processed sequentially 0..BYTES-1 within one cycle.
  - Lane is K28.5 COM (8'hBC, k=1): the LFSR is loaded with LFSR_SEED. Lanes after it in the same word use the reloaded value; the COM lane itself passes unscrambled.
  - Lane is SKP (8'h3C, k=1): the LFSR does not advance.
  - Any other K lane: passes unscrambled; the LFSR advances one byte.
  - D lane with scram_en = 1: data XOR LFSR byte; the LFSR advances.
  - scram_en = 0: data passes through. COM detection is ignored; LFSR is held at LFSR_SEED.
  - LFSR never advances during inserted SKP words.
- Symbol counter:
  - Width clog2(SKP_INTERVAL+BYTES).
  - Adds BYTES for every consumed input word while skp_en = 1.
  - If cnt+BYTES >= SKP_INTERVAL: cnt = cnt+BYTES-SKP_INTERVAL (the remainder carries, no drift) and one credit is added.
  - Held at 0 while skp_en = 0.
- Queue:
  - Credit add and insertion decrement in the same cycle: net = queue + 1 - dec.
  - Add at queue == MAX_QUEUED with no decrement: queue stays, err_skp_overflow is set (sticky until reset).
- skp_inhibit asserted during a stall: raw_stall drops the same cycle; the word is consumed normally.

Test Plan:
- BYTES=4, scram_en=1: COM in lane 0, then D 00 00 00 in lanes 1-3 -> lanes 1-3 = 8'hFF, 8'h17, 8'hC0 (LFSR from FFFF); next word of zeros continues the spec sequence (14 B2 E7).
- COM in lane 2 of a word of D zeros -> lanes 0-1 scrambled by the running LFSR; lane 3 = 8'hFF from the reloaded seed.
- SKP_INTERVAL=16, BYTES=4, raw_active=0, continuous input -> one credit per 4 consumed words; SKP word 3C3C3C3C/K=1111 one cycle after raw_stall=1; skp_queued returns to 0.
- Same config, raw_active=1 for 40 words -> queue reaches 4 then saturates; err_skp_overflow=1; after raw_active falls, 2 SKP words are emitted back to back, with 2 stall cycles.
- BYTES=2, queue=1, skp_defer pulsed 3 cycles -> no insertion during defer; single 3C3C word afterwards; data order preserved, none lost or duplicated.
- reset_n=0 for one cycle mid-insertion with queue=3 -> next cycle proc_*=0, raw_stall=0, skp_queued=0, LFSR=FFFF.
